sort_buffer: RTL
================

// Module: sort_buffer
// PURPOSE
//   Collects up to DEPTH unsigned words, sorts them ascending with an odd-even
//   transposition network (one pass per cycle), and exposes the result through
//   a registered read port. Sits downstream of the 32-bit Avalon register slave:
//   the slave's write strobe drives wr_en and its exported word drives wr_data.
//   Control (start/clear) and readback are driven by the same slave set.
// PARAMETERS
//   WIDTH  32  data word width in bits
//   DEPTH  8   number of storage slots; must be a power of two, >= 2
//   AW     3   address width, = log2(DEPTH)
// PORTS
//   clock    in   1        system clock, rising edge
//   resetn   in   1        asynchronous reset, active-low
//   wr_en    in   1        load wr_data into the next free slot
//   wr_data  in   WIDTH    word to load
//   start    in   1        begin sort of loaded words
//   clear    in   1        discard contents, return to IDLE
//   rd_addr  in   AW       slot index to read
//   rd_data  out  WIDTH    registered contents of slot rd_addr
//   count    out  AW+1     number of words loaded (0..DEPTH)
//   full     out  1        count == DEPTH
//   busy     out  1        high while state == SORT
//   done     out  1        high while state == SORTED
// BEHAVIOUR
//   Reset (resetn=0, async): all slots 0, count 0, pass counter 0, state IDLE,
//     rd_data 0, busy 0, done 0, full 0.
//   States: IDLE -> SORT -> SORTED -> IDLE.
//   Priority each cycle: clear > start > wr_en.
//   IDLE: wr_en && !full && !start: slot[count] <= wr_data, count++.
//     wr_en while full: ignored, no state change.
//     start && count != 0: slots with index >= count are loaded with all-ones
//     (2^WIDTH-1), pass counter <= 0, state -> SORT. wr_en in the same cycle is dropped.
//     start && count == 0: ignored.
//   SORT: exactly DEPTH cycles. For pass p: p even compares pairs (0,1),(2,3)..;
//     p odd compares pairs (1,2),(3,4)..; swaps where slot[i] > slot[i+1]
//     (unsigned). After pass DEPTH-1: state -> SORTED. wr_en/start ignored.
//   SORTED: slots 0..count-1 hold the loaded words in ascending order;
//     duplicates are preserved. wr_en/start ignored. count unchanged.
//   clear (any state): next cycle state IDLE, count 0, pass counter 0;
//     slot contents need not be zeroed.
//   busy/done are registered state decodes, valid the cycle after the transition.
//     Sequence is start at cycle 0 -> busy cycles 1..DEPTH -> done from cycle DEPTH+1.
//   rd_data <= slot[rd_addr] every cycle in every state, with 1-cycle latency.
//     Values read during SORT are intermediate and not meaningful.
//   full = (count == DEPTH); count never exceeds DEPTH.
// TESTING
//   1. DEPTH=8. Load 5,3,9,1; start -> busy for 8 cycles, done=1; rd 0..3 = 1,3,5,9.
//      Then rd 4..7 = FFFFFFFF.
//   2. Load 8 words 8..1 -> full=1, count=8; 9th wr_en ignored; after sort, rd 0..7 = 1..8.
//   3. Load FFFFFFFF,0,FFFFFFFF,7; sort -> rd 0..3 = 0,7,FFFFFFFF,FFFFFFFF.
//   4. start with count=0 -> busy stays 0, state IDLE. start+wr_en same cycle with
//      count=2 -> count stays 2, sort runs.
//   5. clear on 3rd SORT cycle -> next cycle busy=0, done=0, count=0. New loads accepted.
//   6. resetn low mid-SORT (async, between edges) -> outputs 0 immediately.
//      After release, load 2,1 and sort -> 1,2.

Source files
------------

// File: rtl/sort_buffer_if.sv
// Host-side bus for sort_buffer: load/start/clear controls and registered readback.
interface sort_buffer_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             clear;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      count;
    logic             full;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_data, start, clear, rd_addr,
        input  rd_data, count, full, busy, done
    );
    modport slave (
        input  wr_en, wr_data, start, clear, rd_addr,
        output rd_data, count, full, busy, done
    );
endinterface

// File: rtl/sort_buffer.sv
// Loads up to DEPTH words, sorts them ascending with an odd-even transposition
// network (one pass per cycle) and serves the result through a registered read port.
module sort_buffer_cas #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic             swap
);
    assign swap = en && (a > b);
endmodule

module sort_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clock,
    input  logic         resetn,
    sort_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SORT, SORTED} state_t;

    state_t                      state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] slot, slot_net;
    logic [DEPTH-2:0]            swap;
    logic [AW:0]                 count;
    logic [AW-1:0]               pass;
    logic [WIDTH-1:0]            rd_q;
    logic                        busy_q, done_q;
    logic                        full, do_start, do_load, last_pass;

    assign full      = (count == (AW+1)'(DEPTH));
    assign do_start  = !bus.clear && (state == IDLE) && bus.start && (count != '0);
    assign do_load   = !bus.clear && (state == IDLE) && bus.wr_en && !bus.start && !full;
    assign last_pass = (pass == AW'(DEPTH - 1));

    // Pair (i,i+1) is active when i's parity matches the pass parity.
    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_cas
        sort_buffer_cas #(.WIDTH(WIDTH)) u_cas (
            .a    (slot[i]),
            .b    (slot[i+1]),
            .en   (pass[0] == 1'(i % 2)),
            .swap (swap[i])
        );
    end

    // Active pairs never overlap, so each slot takes at most one neighbour.
    for (genvar i = 0; i < DEPTH; i++) begin : g_net
        if (i == 0) begin : g_first
            assign slot_net[i] = swap[i] ? slot[i+1] : slot[i];
        end else if (i == DEPTH - 1) begin : g_last
            assign slot_net[i] = swap[i-1] ? slot[i-1] : slot[i];
        end else begin : g_mid
            assign slot_net[i] = swap[i]   ? slot[i+1] :
                                 swap[i-1] ? slot[i-1] : slot[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (do_start)  state_nxt = SORT;
                SORT:    if (last_pass) state_nxt = SORTED;
                SORTED:  state_nxt = SORTED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot   <= '0;
            count  <= '0;
            pass   <= '0;
            rd_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rd_q   <= slot[bus.rd_addr];
            busy_q <= (state_nxt == SORT);
            done_q <= (state_nxt == SORTED);
            if (bus.clear) begin
                count <= '0;
                pass  <= '0;
            end else if (do_start) begin
                pass <= '0;
                // Pad unused slots with the maximum so they settle at the top.
                for (int i = 0; i < DEPTH; i++)
                    if ((AW+1)'(i) >= count) slot[i] <= '1;
            end else if (do_load) begin
                slot[count[AW-1:0]] <= bus.wr_data;
                count               <= count + 1'b1;
            end else if (state == SORT) begin
                slot <= slot_net;
                pass <= pass + 1'b1;
            end
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.count   = count;
    assign bus.full    = full;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
